// File: rtl/onchip_ram_arbiter.sv
// onchip_ram_arbiter
//   Two-master round-robin sequencer in front of a single-port on-chip RAM
//   whose inputs are registered and whose q is unregistered. Commands are
//   serialised one at a time: IDLE picks a winner, ACCESS presents it to the
//   RAM, READ captures q and returns it to the granted master.
module onchip_ram_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // master 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // RAM slave
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_clken,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;   // 1: m1 held the most recent grant

  logic              req0;
  logic              req1;
  logic              win0;
  logic              win1;
  logic              accept;

  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wr;

  // ACCESS stage: command latched at the accept edge
  logic [ADDR_W-1:0] cmd_addr_p0;
  logic [BE_W-1:0]   cmd_be_p0;
  logic [DATA_W-1:0] cmd_wdata_p0;
  logic              cmd_wr_p0;
  logic              acc_p0;

  // return stage: read data and its valid pulse per master
  logic [DATA_W-1:0] rdata0_p1;
  logic [DATA_W-1:0] rdata1_p1;
  logic              vld0_p1;
  logic              vld1_p1;

  // Round-robin winner selection and mux of the winner's command.
  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    // on a tie the master that did not win last time goes first
    win0      = req0 & (~req1 | last_grant);
    win1      = req1 & (~req0 | ~last_grant);
    accept    = (state == IDLE) & (win0 | win1);
    sel_addr  = m0_address;
    sel_be    = m0_byteenable;
    sel_wdata = m0_writedata;
    sel_wr    = m0_write;
    if (win1) begin
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
      sel_wr    = m1_write;
    end
  end

  // waitrequest drops only for the IDLE-cycle winner; held high while in reset
  assign m0_waitrequest = ~(reset_n & (state == IDLE) & win0);
  assign m1_waitrequest = ~(reset_n & (state == IDLE) & win1);

  // RAM side: address/data hold their last value outside ACCESS
  assign ram_address    = cmd_addr_p0;
  assign ram_byteenable = cmd_be_p0;
  assign ram_writedata  = cmd_wdata_p0;
  assign ram_chipselect = acc_p0;
  assign ram_clken      = acc_p0;
  assign ram_write      = acc_p0 & cmd_wr_p0;

  assign m0_readdata      = rdata0_p1;
  assign m1_readdata      = rdata1_p1;
  assign m0_readdatavalid = vld0_p1;
  assign m1_readdatavalid = vld1_p1;

  // Sequencer FSM: accept, present to RAM, capture read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cmd_addr_p0  <= '0;
      cmd_be_p0    <= '0;
      cmd_wdata_p0 <= '0;
      cmd_wr_p0    <= 1'b0;
      acc_p0       <= 1'b0;
      rdata0_p1    <= '0;
      rdata1_p1    <= '0;
      vld0_p1      <= 1'b0;
      vld1_p1      <= 1'b0;
    end else begin
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // a simultaneous read+write is taken as a write
            cmd_addr_p0  <= sel_addr;
            cmd_be_p0    <= sel_be;
            cmd_wdata_p0 <= sel_wdata;
            cmd_wr_p0    <= sel_wr;
            last_grant   <= win1;
            acc_p0       <= 1'b1;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          // RAM registers its inputs at the end of this cycle
          acc_p0 <= 1'b0;
          state  <= cmd_wr_p0 ? IDLE : READ;
        end
        READ: begin
          // RAM input regs are holding, so q is stable here
          if (last_grant) begin
            rdata1_p1 <= ram_readdata;
            vld1_p1   <= 1'b1;
          end else begin
            rdata0_p1 <= ram_readdata;
            vld0_p1   <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          acc_p0 <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// tb_onchip_ram_arbiter
//   Directed bench for onchip_ram_arbiter with a behavioural 128x32 RAM
//   (registered inputs, unregistered q) attached to the RAM port.
module tb_onchip_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [6:0]  m0_address = '0;
  logic [3:0]  m0_byteenable = '0;
  logic        m0_read = 1'b0;
  logic        m0_write = 1'b0;
  logic [31:0] m0_writedata = '0;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;

  logic [6:0]  m1_address = '0;
  logic [3:0]  m1_byteenable = '0;
  logic        m1_read = 1'b0;
  logic        m1_write = 1'b0;
  logic [31:0] m1_writedata = '0;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;

  logic [6:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_clken;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  onchip_ram_arbiter #(.ADDR_W(7), .DATA_W(32), .BE_W(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_clken        (ram_clken),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_readdata     (ram_readdata)
  );

  always #5 clk = ~clk;

  // RAM model: inputs registered when clken & chipselect, q follows the address reg
  logic [31:0] mem [0:127];
  logic [6:0]  ram_a_r = '0;
  initial for (int k = 0; k < 128; k++) mem[k] = 32'h0;
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      ram_a_r <= ram_address;
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    end
  end
  assign ram_readdata = mem[ram_a_r];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int grant_log[$];
  int acc_cyc[2] = '{0, 0};
  int rdv_n[2] = '{0, 0};
  int last_rdv_cyc = 0;

  // mid-cycle monitor of accepts and readdatavalid pulses
  always @(negedge clk) begin
    if (reset_n) begin
      if ((m0_read || m0_write) && !m0_waitrequest) begin grant_log.push_back(0); acc_cyc[0] = cyc; end
      if ((m1_read || m1_write) && !m1_waitrequest) begin grant_log.push_back(1); acc_cyc[1] = cyc; end
      if (m0_readdatavalid) rdv_n[0]++;
      if (m1_readdatavalid) rdv_n[1]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input logic [6:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  function automatic logic wreq(input int m);
    return (m == 0) ? m0_waitrequest : m1_waitrequest;
  endfunction

  function automatic logic rvld(input int m);
    return (m == 0) ? m0_readdatavalid : m1_readdatavalid;
  endfunction

  function automatic logic [31:0] rdat(input int m);
    return (m == 0) ? m0_readdata : m1_readdata;
  endfunction

  // Called 2ns after a rising edge; returns 2ns after the accept edge.
  task automatic cmd(input int m, input bit rd, input bit wr, input logic [6:0] a,
                     input logic [3:0] be, input logic [31:0] d, input bit hold);
    int n = 0;
    drive(m, rd, wr, a, be, d);
    @(negedge clk);
    while (wreq(m) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk($sformatf("accept_timeout_m%0d", m), 32'(n), 32'd0);
    @(posedge clk); #2;
    if (!hold) drive(m, 1'b0, 1'b0, a, be, d);
  endtask

  // Wait for the read return of master m; checks data, latency and pulse width.
  task automatic wait_rdv(input int m, input logic [31:0] exp, input string tag);
    int n = 0;
    @(negedge clk);
    while (!rvld(m) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, 32'(rvld(m)), 32'd1);
    chk({tag, "_data"}, rdat(m), exp);
    chk({tag, "_lat"}, 32'(cyc - acc_cyc[m]), 32'd3);
    last_rdv_cyc = cyc;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(rvld(m)), 32'd0);
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  int snap;
  int t6_rdv_cyc;

  initial begin
    // reset: a pending request must not be granted while reset is held
    m0_read = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
    chk("rst_wait1", 32'(m1_waitrequest), 32'd1);
    chk("rst_cs", 32'(ram_chipselect), 32'd0);
    chk("rst_clken", 32'(ram_clken), 32'd0);
    chk("rst_write", 32'(ram_write), 32'd0);
    chk("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
    chk("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
    chk("rst_rdata0", m0_readdata, 32'h0);
    chk("rst_rdata1", m1_readdata, 32'h0);
    m0_read = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;

    // 1: m0 write then read of 0x05
    cmd(0, 1'b0, 1'b1, 7'h05, 4'hF, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("t1_acc_cs", 32'(ram_chipselect), 32'd1);
    chk("t1_acc_clken", 32'(ram_clken), 32'd1);
    chk("t1_acc_write", 32'(ram_write), 32'd1);
    chk("t1_acc_addr", 32'(ram_address), 32'h05);
    chk("t1_acc_wdata", ram_writedata, 32'hDEADBEEF);
    chk("t1_acc_wait0", 32'(m0_waitrequest), 32'd1);
    drive(0, 1'b0, 1'b0, 7'h05, 4'hF, 32'h0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("t1_idle_cs", 32'(ram_chipselect), 32'd0);
    chk("t1_idle_write", 32'(ram_write), 32'd0);
    chk("t1_addr_hold", 32'(ram_address), 32'h05);
    @(posedge clk); #2;
    cmd(0, 1'b1, 1'b0, 7'h05, 4'hF, 32'h0, 1'b0);
    wait_rdv(0, 32'hDEADBEEF, "t1_rd");

    // 2: simultaneous continuous requests after reset alternate m0,m1,...
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++)
          cmd(0, 1'b0, 1'b1, 7'(32'h20 + i), 4'hF, 32'hA000_0000 + i, i < 3);
      end
      begin
        for (int j = 0; j < 4; j++)
          cmd(1, 1'b0, 1'b1, 7'(32'h30 + j), 4'hF, 32'hB000_0000 + j, j < 3);
      end
    join
    chk("t2_ngrants", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
    cmd(1, 1'b1, 1'b0, 7'h22, 4'hF, 32'h0, 1'b0);
    wait_rdv(1, 32'hA000_0002, "t2_rd");

    // 3: byte write at the top address, bottom address untouched
    cmd(0, 1'b0, 1'b1, 7'h7F, 4'hF, 32'h11223344, 1'b0);
    cmd(0, 1'b0, 1'b1, 7'h00, 4'hF, 32'hCAFEF00D, 1'b0);
    cmd(1, 1'b0, 1'b1, 7'h7F, 4'b0001, 32'h000000AA, 1'b0);
    @(negedge clk);
    chk("t3_be", 32'(ram_byteenable), 32'h1);
    chk("t3_addr", 32'(ram_address), 32'h7F);
    @(posedge clk); #2;
    cmd(1, 1'b1, 1'b0, 7'h7F, 4'hF, 32'h0, 1'b0);
    wait_rdv(1, 32'h112233AA, "t3_rd7f");
    cmd(0, 1'b1, 1'b0, 7'h00, 4'hF, 32'h0, 1'b0);
    wait_rdv(0, 32'hCAFEF00D, "t3_rd00");
    chk("t3_m1_rdata_hold", m1_readdata, 32'h112233AA);

    // 4: read+write together is a write with no read return
    snap = rdv_n[0];
    cmd(0, 1'b1, 1'b1, 7'h10, 4'hF, 32'h5, 1'b0);
    @(negedge clk);
    chk("t4_write", 32'(ram_write), 32'd1);
    repeat (4) @(negedge clk);
    chk("t4_no_rdv", 32'(rdv_n[0]), 32'(snap));
    @(posedge clk); #2;
    cmd(0, 1'b1, 1'b0, 7'h10, 4'hF, 32'h0, 1'b0);
    wait_rdv(0, 32'h5, "t4_rd");

    // 5a: reset while in ACCESS drops the strobes at once
    cmd(1, 1'b0, 1'b1, 7'h50, 4'hF, 32'h1, 1'b0);
    #1;
    chk("t5a_cs_before", 32'(ram_chipselect), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5a_cs", 32'(ram_chipselect), 32'd0);
    chk("t5a_clken", 32'(ram_clken), 32'd0);
    chk("t5a_write", 32'(ram_write), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;

    // 5: reset during READ; no return, then m0 wins the first tie
    cmd(0, 1'b1, 1'b0, 7'h05, 4'hF, 32'h0, 1'b0);
    @(posedge clk); #2;
    drive(0, 1'b1, 1'b0, 7'h05, 4'hF, 32'h0);
    drive(1, 1'b0, 1'b1, 7'h44, 4'hF, 32'h44);
    reset_n = 1'b0;
    #1;
    chk("t5_cs", 32'(ram_chipselect), 32'd0);
    chk("t5_clken", 32'(ram_clken), 32'd0);
    chk("t5_wait0", 32'(m0_waitrequest), 32'd1);
    chk("t5_wait1", 32'(m1_waitrequest), 32'd1);
    chk("t5_rdv0", 32'(m0_readdatavalid), 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_rdv0_held", 32'(m0_readdatavalid), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    grant_log.delete();
    fork
      begin
        cmd(0, 1'b1, 1'b0, 7'h05, 4'hF, 32'h0, 1'b0);
        wait_rdv(0, 32'hDEADBEEF, "t5_rd");
      end
      cmd(1, 1'b0, 1'b1, 7'h44, 4'hF, 32'h44, 1'b0);
    join
    chk("t5_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // 6: m1 accepted in the cycle m0's read returns
    snap = rdv_n[1];
    fork
      begin
        cmd(0, 1'b1, 1'b0, 7'h05, 4'hF, 32'h0, 1'b0);
        wait_rdv(0, 32'hDEADBEEF, "t6_rd");
        t6_rdv_cyc = last_rdv_cyc;
      end
      cmd(1, 1'b0, 1'b1, 7'h45, 4'hF, 32'h45, 1'b0);
    join
    chk("t6_m1_accept_cyc", 32'(acc_cyc[1]), 32'(t6_rdv_cyc));
    repeat (3) @(negedge clk);
    chk("t6_no_rdv1", 32'(rdv_n[1]), 32'(snap));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
